iter_counter: RTL

//  Parametrised W-bit iteration counter with start/done handshake for the FP32 iterative datapaths
//  (normalisation shift, mantissa divide/sqrt step count). Supports up/down direction and one-shot or

---
 rtl/counter_pkg.sv | 15 +
 rtl/iter_counter.sv | 102 ++++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the iteration counter.
// Holds the FSM state enum and the direction / mode encodings.
package counter_pkg;

    typedef enum logic {
        CNT_IDLE,
        CNT_RUN
    } cnt_state_e;

    localparam logic CNT_DOWN    = 1'b0;
    localparam logic CNT_UP      = 1'b1;
    localparam logic CNT_ONESHOT = 1'b0;
    localparam logic CNT_RELOAD  = 1'b1;

endpackage

// File: rtl/iter_counter.sv
// W-bit iteration counter with start/done handshake, up/down, one-shot/reload.
// Ports: clk, reset (sync, active-low), start, ld_data[W], dir, mode, en,
//        abort -> Q[W] (count), busy (in RUN), tc (at terminal), done (pulse).
module iter_counter
    import counter_pkg::*;
#(
    parameter int unsigned     W       = 5,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] ld_data,
    input  logic         dir,
    input  logic         mode,
    input  logic         en,
    input  logic         abort,
    output logic [W-1:0] Q,
    output logic         busy,
    output logic         tc,
    output logic         done
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    cnt_state_e   state_q, state_n;
    logic [W-1:0] q_q, q_n;
    logic [W-1:0] bound_q, bound_n;
    logic         dir_q, dir_n;
    logic         mode_q, mode_n;
    logic         done_q, done_n;

    logic [W-1:0] t_val;
    logic [W-1:0] s_val;
    logic         at_t;

    // Terminal and start values follow the direction captured at start.
    always_comb begin
        t_val = (dir_q == CNT_UP) ? bound_q : '0;
        s_val = (dir_q == CNT_UP) ? '0 : bound_q;
        at_t  = (q_q == t_val);
    end

    assign busy = (state_q == CNT_RUN);
    assign tc   = busy && at_t;
    assign Q    = q_q;
    assign done = done_q;

    // Priority: abort > start > en. Counting stops at T, so Q stays
    // inside [0, bound_q] and never wraps.
    always_comb begin
        state_n = state_q;
        q_n     = q_q;
        bound_n = bound_q;
        dir_n   = dir_q;
        mode_n  = mode_q;
        done_n  = 1'b0;
        if (abort) begin
            if (state_q == CNT_RUN) begin
                state_n = CNT_IDLE;
            end
        end else if (start) begin
            bound_n = ld_data;
            dir_n   = dir;
            mode_n  = mode;
            q_n     = (dir == CNT_UP) ? '0 : ld_data;
            state_n = CNT_RUN;
        end else if (state_q == CNT_RUN && en) begin
            if (at_t) begin
                done_n = 1'b1;
                if (mode_q == CNT_RELOAD) begin
                    q_n = s_val;
                end else begin
                    state_n = CNT_IDLE;
                end
            end else if (dir_q == CNT_UP) begin
                q_n = q_q + ONE;
            end else begin
                q_n = q_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CNT_IDLE;
            q_q     <= RST_VAL;
            bound_q <= '0;
            dir_q   <= CNT_DOWN;
            mode_q  <= CNT_ONESHOT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            q_q     <= q_n;
            bound_q <= bound_n;
            dir_q   <= dir_n;
            mode_q  <= mode_n;
            done_q  <= done_n;
        end
    end

endmodule
